// File: rtl/fetch_unit.sv
// Instruction fetch stage: assembles one- and two-byte instructions from a
// byte-wide program memory and presents them to decode with stall/flush control.
module fetch_unit #(
  parameter int          OP_LEN_BIT = 7,
  parameter logic [7:0]  NOP_CODE   = 8'h00
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] PC_in,
  input  logic [7:0] IM_data,
  input  logic       stall,
  input  logic       flush,
  output logic       I_PC,
  output logic [7:0] IR1_out,
  output logic [7:0] IR2_out,
  output logic [7:0] IR_PC_out,
  output logic       valid_out
);

  // state | meaning
  // OP    | fetching an opcode byte
  // ARG   | opcode latched, fetching its operand byte
  localparam logic ST_OP  = 1'b0;
  localparam logic ST_ARG = 1'b1;

  logic       state;
  logic [7:0] op_reg;
  logic [7:0] pc_reg;
  logic       slot_free;
  logic       fetch_en;

  assign slot_free = !valid_out || !stall;
  assign fetch_en  = slot_free && !flush;
  assign I_PC      = !RST && fetch_en;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_OP;
      valid_out <= 1'b0;
      IR1_out   <= NOP_CODE;
      IR2_out   <= 8'h00;
      IR_PC_out <= 8'h00;
      op_reg    <= 8'h00;
      pc_reg    <= 8'h00;
    end else if (flush) begin
      // A partial two-byte fetch is simply dropped; op_reg/pc_reg get rewritten.
      state     <= ST_OP;
      valid_out <= 1'b0;
      IR1_out   <= NOP_CODE;
      IR2_out   <= 8'h00;
    end else if (fetch_en) begin
      case (state)
        ST_OP: begin
          op_reg <= IM_data;
          pc_reg <= PC_in;
          if (IM_data[OP_LEN_BIT]) begin
            state     <= ST_ARG;
            valid_out <= 1'b0;
          end else begin
            IR1_out   <= IM_data;
            IR2_out   <= 8'h00;
            IR_PC_out <= PC_in;
            valid_out <= 1'b1;
          end
        end
        default: begin
          IR1_out   <= op_reg;
          IR2_out   <= IM_data;
          IR_PC_out <= pc_reg;
          valid_out <= 1'b1;
          state     <= ST_OP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: the bench plays program counter and memory,
// checking each presented instruction against hand-computed values.
module tb_fetch_unit;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] PC_in;
  logic [7:0] IM_data;
  logic       stall;
  logic       flush;
  logic       I_PC;
  logic [7:0] IR1_out;
  logic [7:0] IR2_out;
  logic [7:0] IR_PC_out;
  logic       valid_out;

  logic [7:0] mem [256];
  logic [7:0] flush_tgt;
  int checks = 0;
  int errors = 0;

  fetch_unit dut (
    .CLK(CLK), .RST(RST), .PC_in(PC_in), .IM_data(IM_data),
    .stall(stall), .flush(flush), .I_PC(I_PC),
    .IR1_out(IR1_out), .IR2_out(IR2_out), .IR_PC_out(IR_PC_out),
    .valid_out(valid_out)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic chk_ins(input string tag, input logic [7:0] ir1, input logic [7:0] ir2,
                         input logic [7:0] pc, input logic vld);
    chk({tag, ".ir1"}, IR1_out, ir1);
    chk({tag, ".ir2"}, IR2_out, ir2);
    chk({tag, ".pc"}, IR_PC_out, pc);
    chk({tag, ".valid"}, {7'd0, valid_out}, {7'd0, vld});
  endtask

  // One clock: program counter follows I_PC / flush exactly as the real PC would.
  task automatic cyc();
    logic ipc;
    logic fl;
    ipc = I_PC;
    fl  = flush;
    @(posedge CLK);
    #1;
    if (fl)       PC_in = flush_tgt;
    else if (ipc) PC_in = PC_in + 8'd1;
    IM_data = mem[PC_in];
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h05; mem[8'h01] = 8'h06; mem[8'h02] = 8'h8A; mem[8'h03] = 8'h3C;
    mem[8'h04] = 8'h11; mem[8'h05] = 8'h22; mem[8'h06] = 8'h8B; mem[8'h07] = 8'h44;
    mem[8'h40] = 8'h33; mem[8'hFF] = 8'h07; mem[8'h10] = 8'h12;
    RST = 1'b1; stall = 1'b0; flush = 1'b0; flush_tgt = 8'h00;
    PC_in = 8'h00; IM_data = mem[8'h00];

    @(posedge CLK); #1;
    chk_ins("reset", 8'h00, 8'h00, 8'h00, 1'b0);
    chk("reset.ipc", {7'd0, I_PC}, 8'h00);
    chk("reset.state", {7'd0, dut.state}, 8'h00);
    @(posedge CLK); #1;
    RST = 1'b0;
    #1;
    chk("run.ipc0", {7'd0, I_PC}, 8'h01);

    // one-byte stream
    cyc(); chk_ins("one0", 8'h05, 8'h00, 8'h00, 1'b1);
    chk("one0.ipc", {7'd0, I_PC}, 8'h01);
    cyc(); chk_ins("one1", 8'h06, 8'h00, 8'h01, 1'b1);

    // two-byte 8A 3C
    cyc(); chk("two.v0", {7'd0, valid_out}, 8'h00);
    chk("two.state", {7'd0, dut.state}, 8'h01);
    chk("two.ipc", {7'd0, I_PC}, 8'h01);
    cyc(); chk_ins("two", 8'h8A, 8'h3C, 8'h02, 1'b1);

    // stall for 3 cycles
    cyc(); chk_ins("pre_stall", 8'h11, 8'h00, 8'h04, 1'b1);
    stall = 1'b1; #1;
    chk("stall.ipc", {7'd0, I_PC}, 8'h00);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_ins("stall", 8'h11, 8'h00, 8'h04, 1'b1);
      chk("stall.ipc_hold", {7'd0, I_PC}, 8'h00);
      chk("stall.pc", PC_in, 8'h05);
    end
    stall = 1'b0; #1;
    chk("unstall.ipc", {7'd0, I_PC}, 8'h01);
    cyc(); chk_ins("unstall", 8'h22, 8'h00, 8'h05, 1'b1);

    // flush in ARG with stall in the same cycle
    cyc(); chk("fl.arg", {7'd0, dut.state}, 8'h01);
    stall = 1'b1; flush = 1'b1; flush_tgt = 8'h40; #1;
    chk("fl.ipc", {7'd0, I_PC}, 8'h00);
    cyc();
    flush = 1'b0; stall = 1'b0; #1;
    chk_ins("flush", 8'h00, 8'h00, 8'h05, 1'b0);
    chk("flush.state", {7'd0, dut.state}, 8'h00);
    chk("flush.newpc", PC_in, 8'h40);
    cyc(); chk_ins("postflush", 8'h33, 8'h00, 8'h40, 1'b1);

    // PC wrap FF -> 00
    flush = 1'b1; flush_tgt = 8'hFF; #1;
    cyc();
    flush = 1'b0;
    mem[8'h00] = 8'h09; mem[8'h01] = 8'h8C; mem[8'h02] = 8'h55;
    #1;
    cyc(); chk_ins("wrapFF", 8'h07, 8'h00, 8'hFF, 1'b1);
    cyc(); chk_ins("wrap00", 8'h09, 8'h00, 8'h00, 1'b1);

    // async reset mid two-byte fetch
    cyc(); chk("ar.state", {7'd0, dut.state}, 8'h01);
    chk("ar.ir1", IR1_out, 8'h09);
    #2 RST = 1'b1;
    #1;
    chk_ins("async_rst", 8'h00, 8'h00, 8'h00, 1'b0);
    chk("async_rst.ipc", {7'd0, I_PC}, 8'h00);
    chk("async_rst.state", {7'd0, dut.state}, 8'h00);
    RST = 1'b0;
    PC_in = 8'h10; IM_data = mem[8'h10];
    cyc(); chk_ins("post_rst", 8'h12, 8'h00, 8'h10, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter OP_LEN_BIT, default 7, the opcode bit that marks a two-byte instruction when 1.
REQ-002 SHALL have parameter NOP_CODE, default 8'h00, the opcode presented on IR1_out when no instruction is valid.
REQ-003 CLK  input  1  single clock; all state changes on the posedge.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 PC_in  input  8  current PC value (the program counter's PC_out).
REQ-006 IM_data  input  8  program-memory byte at PC_in, combinational, valid in the same cycle.
REQ-007 stall  input  1  decode cannot accept; hold the current output instruction.
REQ-008 flush  input  1  taken branch/jump this cycle; PC is being loaded (L_PC=1).
REQ-009 I_PC  output  1  PC increment request, driven to the program counter's I_PC.
REQ-010 IR1_out  output  8  opcode of the presented instruction.
REQ-011 IR2_out  output  8  operand byte; 8'h00 for one-byte instructions.
REQ-012 IR_PC_out  output  8  address of the opcode byte of the presented instruction.
REQ-013 valid_out  output  1  IR1/IR2/IR_PC hold a real instruction.

Function
REQ-014 SHALL implement a two-state FSM: OP (fetching an opcode byte) and ARG (fetching an operand byte).
REQ-015 SHALL define slot_free = !valid_out || !stall, evaluated combinationally each cycle.
REQ-016 In OP with slot_free and !flush, SHALL assert I_PC=1 and latch IM_data into an internal opcode register and PC_in into an internal PC register.
REQ-017 In OP, if IM_data[OP_LEN_BIT]=0, SHALL on the same edge load IR1_out=IM_data, IR2_out=8'h00, IR_PC_out=PC_in and valid_out=1, and remain in OP.
REQ-018 In OP, if IM_data[OP_LEN_BIT]=1, SHALL go to ARG, and valid_out SHALL go to 0 on that edge.
REQ-019 In ARG with slot_free and !flush, SHALL assert I_PC=1 and load IR1_out=opcode register, IR2_out=IM_data, IR_PC_out=PC register and valid_out=1, then return to OP.
REQ-020 When !slot_free, SHALL hold state, all outputs and internal registers, and drive I_PC=0.
REQ-021 Latency: a one-byte instruction SHALL be valid 1 cycle after its byte is at PC_in; a two-byte instruction SHALL be valid 1 cycle after its operand byte is at PC_in, which is 2 cycles after the opcode.
REQ-022 A valid instruction SHALL be consumed on any posedge where valid_out=1 and stall=0; I_PC SHALL never be asserted while the slot is held.
REQ-023 flush SHALL take priority over stall and over every fetch: I_PC=0 combinationally, and on the edge valid_out=0, IR1_out=NOP_CODE, IR2_out=8'h00, and state=OP, discarding any partial two-byte fetch.
REQ-024 On the cycle after a flush, SHALL fetch normally from the newly loaded PC.
REQ-025 PC wrap from 8'hFF to 8'h00 SHALL need no special handling; IR_PC_out SHALL carry the raw 8-bit address.
REQ-026 I_PC SHALL be purely combinational from state, valid_out, stall, flush and RST, with no registered delay.

Reset
REQ-027 While RST=1, state SHALL be OP, valid_out=0, IR1_out=NOP_CODE, IR2_out=8'h00, IR_PC_out=8'h00, internal registers=0, and I_PC=0.
REQ-028 RST asserted mid two-byte fetch SHALL abandon the fetch immediately, asynchronously.
REQ-029 On the first posedge after RST deasserts, SHALL fetch the opcode at PC_in.

Verification
REQ-030 Reset, then memory 00:05, 01:06, no stall -> I_PC=1 each cycle; IR1 = 05 @PC 00, then 06 @PC 01; IR2=00; one instruction per cycle.
REQ-031 Memory 00:8A, 01:3C -> cycle 1 valid_out=0, state ARG; cycle 2 IR1=8A, IR2=3C, IR_PC=00, valid_out=1.
REQ-032 Valid instruction 05 with stall=1 for 3 cycles -> I_PC=0 and outputs frozen for 3 cycles; next instruction appears 1 cycle after stall drops.
REQ-033 flush in ARG after opcode 8A, with stall=1 in the same cycle -> I_PC=0; next edge valid_out=0, IR1=00, state OP; opcode at new PC fetched on the following cycle.
REQ-034 PC_in=FF holding 07, then 00 holding 09 -> IR_PC_out=FF then 00, with no glitch on valid_out.
REQ-035 RST pulse mid-cycle while in ARG -> outputs return to reset values immediately (asynchronously), without waiting for a CLK edge.
